// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Shared SDRAM controller definitions: command encodings for the
//   {cs_n, ras_n, cas_n, we_n} bus, the refresh scheduler state type and a
//   width helper for counters that must hold 0..max_val.
// -----------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_NOP     = 4'b0111,
    CMD_ACT     = 4'b0011,
    CMD_RD      = 4'b0101,
    CMD_WR      = 4'b0100,
    CMD_PRECH   = 4'b0010,
    CMD_REFRESH = 4'b0001
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECH,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC
  } ref_state_e;

  // Bits needed to represent 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// -----------------------------------------------------------------------------
// sdram_ref_timer
//   Refresh interval timer and refresh debt bookkeeping.
//   The timer counts 0..T_REFI_CYC-1 while enabled and ticks on wrap; each
//   tick adds one owed refresh, each issued REFRESH (dec) removes one.
//   Debt saturates at MAX_DEBT; a tick arriving at saturation sets the sticky
//   overflow flag, which only rst clears.
// Ports
//   sysclk_100M  in   clock
//   rst          in   async reset, active-high
//   enable       in   0 = timer and debt held at 0
//   dec          in   a REFRESH command is on the bus this cycle
//   debt         out  pending refreshes
//   overflow     out  sticky: refresh lost to saturation
// -----------------------------------------------------------------------------
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int T_REFI_CYC = 780,
  parameter int MAX_DEBT   = 8,
  parameter int DEBT_W     = cnt_width(MAX_DEBT)
) (
  input  logic              sysclk_100M,
  input  logic              rst,
  input  logic              enable,
  input  logic              dec,
  output logic [DEBT_W-1:0] debt,
  output logic              overflow
);

  localparam int TMR_W = cnt_width(T_REFI_CYC - 1);

  logic [TMR_W-1:0] tmr;
  logic             tick;
  logic             debt_full;
  logic             debt_zero;

  assign tick      = enable && (tmr == TMR_W'(T_REFI_CYC - 1));
  assign debt_full = (debt == DEBT_W'(MAX_DEBT));
  assign debt_zero = (debt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      tmr      <= '0;
      debt     <= '0;
      overflow <= 1'b0;
    end else if (!enable) begin
      tmr  <= '0;
      debt <= '0;
    end else begin
      tmr <= tick ? '0 : tmr + 1'b1;
      if (tick && debt_full) overflow <= 1'b1;
      // Coincident tick and REFRESH cancel out.
      if (tick && !dec) begin
        if (!debt_full) debt <= debt + 1'b1;
      end else if (dec && !tick) begin
        if (!debt_zero) debt <= debt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_refresh_sched.sv
// -----------------------------------------------------------------------------
// sdram_refresh_sched
//   SDRAM auto-refresh scheduler. Requests the arbiter while refreshes are
//   owed, and once granted issues an optional PRECHARGE-ALL followed by up to
//   BURST_MAX AUTO REFRESH commands, spacing them by tRP / tRFC.
// Ports
//   sysclk_100M           in   clock
//   rst                   in   async reset, active-high
//   enable                in   from init engine; 0 = idle, timer/debt cleared
//   arbit_refresh_req     out  request to arbiter (combinational)
//   arbit_refresh_urgent  out  debt >= URGENT_LVL
//   arbit_refresh_ack     in   grant, held until refresh_end
//   refresh_end           out  1-cycle pulse in the last cycle of the grant
//   cmd_reg               out  {cs_n,ras_n,cas_n,we_n}
//   sdram_a10             out  1 during PRECHARGE (all banks)
//   refresh_debt          out  pending refreshes
//   debt_overflow         out  sticky: tick arrived at MAX_DEBT
// -----------------------------------------------------------------------------
module sdram_refresh_sched
  import sdram_pkg::*;
#(
  parameter int  T_REFI_CYC = 780,
  parameter int  T_RP_CYC   = 2,
  parameter int  T_RFC_CYC  = 7,
  parameter int  MAX_DEBT   = 8,
  parameter int  URGENT_LVL = 6,
  parameter int  BURST_MAX  = 4,
  parameter bit  PRECH_EN   = 1'b1,
  localparam int DEBT_W     = cnt_width(MAX_DEBT)
) (
  input  logic              sysclk_100M,
  input  logic              rst,
  input  logic              enable,
  output logic              arbit_refresh_req,
  output logic              arbit_refresh_urgent,
  input  logic              arbit_refresh_ack,
  output logic              refresh_end,
  output logic [3:0]        cmd_reg,
  output logic              sdram_a10,
  output logic [DEBT_W-1:0] refresh_debt,
  output logic              debt_overflow
);

  localparam int WAIT_MAX = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
  localparam int WAIT_W   = cnt_width(WAIT_MAX);
  localparam int BURST_W  = cnt_width(BURST_MAX);

  ref_state_e         state, state_nx;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               debt_nz;
  logic               wait_last_rp;
  logic               wait_last_rfc;
  logic               burst_more;
  logic               in_wait;

  sdram_ref_timer #(
    .T_REFI_CYC (T_REFI_CYC),
    .MAX_DEBT   (MAX_DEBT),
    .DEBT_W     (DEBT_W)
  ) u_timer (
    .sysclk_100M (sysclk_100M),
    .rst         (rst),
    .enable      (enable),
    .dec         (state == ST_REF),
    .debt        (refresh_debt),
    .overflow    (debt_overflow)
  );

  assign debt_nz = (refresh_debt != '0);
  assign in_wait = (state == ST_WAIT_RP) || (state == ST_WAIT_RFC);

  // wait_cnt is 0 in the first wait cycle, so the last wait cycle before the
  // next command is spacing-2 (the command cycle itself counts as one).
  assign wait_last_rp  = (wait_cnt == WAIT_W'(T_RP_CYC - 2));
  assign wait_last_rfc = (wait_cnt == WAIT_W'(T_RFC_CYC - 2));
  assign burst_more    = debt_nz && (burst_cnt < BURST_W'(BURST_MAX));

  assign arbit_refresh_req    = (state == ST_IDLE) && debt_nz && enable && !arbit_refresh_ack;
  assign arbit_refresh_urgent = (refresh_debt >= DEBT_W'(URGENT_LVL));
  assign refresh_end          = (state == ST_WAIT_RFC) && wait_last_rfc && !burst_more;

  // Ack is only consulted in IDLE: once started, the sequence always runs to
  // completion so tRFC is honoured even if the arbiter misbehaves.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_IDLE:     if (arbit_refresh_ack && debt_nz) state_nx = PRECH_EN ? ST_PRECH : ST_REF;
      ST_PRECH:    state_nx = (T_RP_CYC > 1) ? ST_WAIT_RP : ST_REF;
      ST_WAIT_RP:  if (wait_last_rp) state_nx = ST_REF;
      ST_REF:      state_nx = (T_RFC_CYC > 1) ? ST_WAIT_RFC : ST_IDLE;
      ST_WAIT_RFC: if (wait_last_rfc) state_nx = burst_more ? ST_REF : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Command outputs are registered from the next state so the bus is driven
  // glitch-free from a flop in the same cycle the FSM enters the state.
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_reg   <= CMD_NOP;
      sdram_a10 <= 1'b0;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      sdram_a10 <= (state_nx == ST_PRECH);
      case (state_nx)
        ST_PRECH: cmd_reg <= CMD_PRECH;
        ST_REF:   cmd_reg <= CMD_REFRESH;
        default:  cmd_reg <= CMD_NOP;
      endcase
      wait_cnt <= (in_wait && state_nx == state) ? wait_cnt + 1'b1 : '0;
      if (state == ST_IDLE)     burst_cnt <= '0;
      else if (state == ST_REF) burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_refresh_sched
//   Directed bench: T_REFI=20, T_RP=2, T_RFC=4, MAX_DEBT=4, URGENT=3, BURST=2.
//   dut uses PRECH_EN=1, dut_np uses PRECH_EN=0. Cycle n is the interval after
//   the n-th rising edge counted from the edge at which enable was raised;
//   everything is sampled/driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sdram_refresh_sched;
  import sdram_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, ack, en_np, ack_np;
  logic       req, urg, end_p, a10, ovf;
  logic       req_np, urg_np, end_np, a10_np, ovf_np;
  logic [3:0] cmd, cmd_np;
  logic [2:0] debt, debt_np;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  sdram_refresh_sched #(
    .T_REFI_CYC(20), .T_RP_CYC(2), .T_RFC_CYC(4), .MAX_DEBT(4),
    .URGENT_LVL(3), .BURST_MAX(2), .PRECH_EN(1'b1)
  ) dut (
    .sysclk_100M(clk), .rst(rst), .enable(en),
    .arbit_refresh_req(req), .arbit_refresh_urgent(urg), .arbit_refresh_ack(ack),
    .refresh_end(end_p), .cmd_reg(cmd), .sdram_a10(a10),
    .refresh_debt(debt), .debt_overflow(ovf)
  );

  sdram_refresh_sched #(
    .T_REFI_CYC(20), .T_RP_CYC(2), .T_RFC_CYC(4), .MAX_DEBT(4),
    .URGENT_LVL(3), .BURST_MAX(2), .PRECH_EN(1'b0)
  ) dut_np (
    .sysclk_100M(clk), .rst(rst), .enable(en_np),
    .arbit_refresh_req(req_np), .arbit_refresh_urgent(urg_np), .arbit_refresh_ack(ack_np),
    .refresh_end(end_np), .cmd_reg(cmd_np), .sdram_a10(a10_np),
    .refresh_debt(debt_np), .debt_overflow(ovf_np)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic goto(input int c);
    while (cyc_n < c) step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ack = 1'b0; en_np = 1'b0; ack_np = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_cmd",    cmd,    4'b0111);
    check("rst_req",    req,    1'b0);
    check("rst_urg",    urg,    1'b0);
    check("rst_end",    end_p,  1'b0);
    check("rst_a10",    a10,    1'b0);
    check("rst_debt",   debt,   3'd0);
    check("rst_ovf",    ovf,    1'b0);
    check("rst_cmd_np", cmd_np, 4'b0111);
    rst = 1'b0;
    step();
    cyc_n = 0;
    en    = 1'b1;

    // 1: first tick 20 clocks after enable, single PRECH+REF grant
    goto(19); check("t1_req_pre",  req,  1'b0); check("t1_debt_pre", debt, 3'd0);
    goto(20); check("t1_req",      req,  1'b1); check("t1_debt",     debt, 3'd1);
    goto(21); ack = 1'b1; #1; check("t1_req_ackmask", req, 1'b0);
    goto(22); check("t1_prech", cmd, 4'b0010); check("t1_prech_a10", a10, 1'b1);
    goto(23); check("t1_wrp",   cmd, 4'b0111); check("t1_wrp_a10",   a10, 1'b0);
    goto(24); check("t1_ref",   cmd, 4'b0001); check("t1_ref_debt",  debt, 3'd1);
              check("t1_ref_end", end_p, 1'b0);
    goto(25); check("t1_nop1",  cmd, 4'b0111); check("t1_debt0",     debt, 3'd0);
    goto(26); check("t1_nop2_end", end_p, 1'b0);
    goto(27); check("t1_nop3",  cmd, 4'b0111); check("t1_end",       end_p, 1'b1);
    goto(28); check("t1_end_off", end_p, 1'b0); ack = 1'b0;

    // 2: postponed refreshes, urgent flag, burst capped at BURST_MAX
    goto(79); check("t2_debt2", debt, 3'd2); check("t2_urg0", urg, 1'b0);
    goto(80); check("t2_debt3", debt, 3'd3); check("t2_urg1", urg, 1'b1);
              check("t2_req", req, 1'b1); ack = 1'b1;
    goto(81); check("t2_prech", cmd, 4'b0010);
    goto(83); check("t2_ref1",  cmd, 4'b0001);
    goto(86); check("t2_noend", end_p, 1'b0);
    goto(87); check("t2_ref2",  cmd, 4'b0001); check("t2_debt_r2", debt, 3'd2);
    goto(88); check("t2_debt1", debt, 3'd1);
    goto(90); check("t2_end",   end_p, 1'b1);
    goto(91); ack = 1'b0; #1;
              check("t2_req_again", req, 1'b1); check("t2_debt_left", debt, 3'd1);
              check("t2_urg_off", urg, 1'b0);

    // 3: saturation and sticky overflow
    goto(140); check("t3_debt4", debt, 3'd4); check("t3_ovf0", ovf, 1'b0);
    goto(159); check("t3_ovf_pre", ovf, 1'b0);
    goto(160); check("t3_debt_sat", debt, 3'd4); check("t3_ovf1", ovf, 1'b1); ack = 1'b1;
    goto(161); check("t3_prech", cmd, 4'b0010);
    goto(163); check("t3_ref1",  cmd, 4'b0001);
    goto(164); check("t3_debt3", debt, 3'd3);
    goto(167); check("t3_ref2",  cmd, 4'b0001);
    goto(170); check("t3_end",   end_p, 1'b1);
    goto(171); ack = 1'b0; check("t3_debt2", debt, 3'd2);
    goto(172); ack = 1'b1;
    goto(173); check("t3b_prech", cmd, 4'b0010);
    goto(175); check("t3b_ref1",  cmd, 4'b0001);
    goto(176); check("t3b_debt1", debt, 3'd1);

    // 4: tick coincides with the REFRESH in cycle 179
    goto(179); check("t4_ref",        cmd,  4'b0001); check("t4_debt_at", debt, 3'd1);
    goto(180); check("t4_debt_same",  debt, 3'd1);    check("t4_nop",     cmd,  4'b0111);
    goto(182); check("t4_end",        end_p, 1'b1);
    goto(183); ack = 1'b0; check("t4_debt1", debt, 3'd1);
    goto(184); ack = 1'b1;
    goto(185); check("t3c_prech", cmd, 4'b0010);
    goto(187); check("t3c_ref",   cmd, 4'b0001);
    goto(188); check("t3c_debt0", debt, 3'd0);
    goto(190); check("t3c_end",   end_p, 1'b1);
    goto(191); ack = 1'b0;
               check("t3_ovf_sticky", ovf, 1'b1); check("t3c_req0", req, 1'b0);
               en_np = 1'b1;

    // 5: PRECH_EN=0 instance, enabled at cycle 191
    goto(210); check("t5_req_pre", req_np, 1'b0); check("t5_debt_pre", debt_np, 3'd0);
    goto(211); check("t5_req", req_np, 1'b1); check("t5_debt", debt_np, 3'd1); ack_np = 1'b1;
    goto(212); check("t5_ref_first", cmd_np, 4'b0001); check("t5_a10_212", a10_np, 1'b0);
    goto(213); check("t5_nop1", cmd_np, 4'b0111); check("t5_a10_213", a10_np, 1'b0);
    goto(214); check("t5_a10_214", a10_np, 1'b0);
    goto(215); check("t5_end", end_np, 1'b1); check("t5_a10_215", a10_np, 1'b0);
    goto(216); ack_np = 1'b0; check("t5_debt0", debt_np, 3'd0);
               ack = 1'b1;

    // 6: async reset in the middle of WAIT_RFC, then disabled
    goto(217); check("t6_prech", cmd, 4'b0010);
    goto(219); check("t6_ref",   cmd, 4'b0001);
    goto(220); check("t6_debt1", debt, 3'd1);
    goto(221); rst = 1'b1; #1;
               check("t6_cmd_nop", cmd,  4'b0111);
               check("t6_req0",    req,  1'b0);
               check("t6_debt0",   debt, 3'd0);
               check("t6_ovf_clr", ovf,  1'b0);
               check("t6_end0",    end_p, 1'b0);
    en = 1'b0; ack = 1'b0; en_np = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      check("t6_noreq", req, 1'b0);
    end
    check("t6_debt_idle", debt, 3'd0);
    check("t6_cmd_idle",  cmd,  4'b0111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
